// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM state encoding and grant index width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    function automatic int grant_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational requester selection: round-robin starting after ptr_i, or fixed priority (index 0 highest).
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int GW          = grant_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [GW-1:0]          ptr_i,
    input  logic                   rr_mode_i,
    output logic [GW-1:0]          idx_o,
    output logic                   valid_o
);

    logic [GW-1:0] cand [NUM_MASTERS];

    // cand[k] = (ptr + 1 + k) mod NUM_MASTERS; the sum never reaches 2*NUM_MASTERS
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
        logic [GW:0] sum;
        assign sum      = {1'b0, ptr_i} + (GW+1)'(gi + 1);
        assign cand[gi] = (sum >= (GW+1)'(NUM_MASTERS)) ? GW'(sum - (GW+1)'(NUM_MASTERS))
                                                        : sum[GW-1:0];
    end

    always_comb begin
        logic found;
        found = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found) begin
                if (rr_mode_i && req_i[cand[i]]) begin
                    idx_o = cand[i];
                    found = 1'b1;
                end else if (!rr_mode_i && req_i[i]) begin
                    idx_o = GW'(i);
                    found = 1'b1;
                end
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-master arbiter in front of a single memory controller port (IDLE/ISSUE/WAIT/DONE).
// Define MEM_ARB_TIMEOUT_EN to add a WAIT watchdog and the timeout_err output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 2,
    parameter  int ADDR_WIDTH     = 24,
    parameter  int DATA_WIDTH     = 16,
    parameter  int RR_EN          = 1,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int GW             = grant_width(NUM_MASTERS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_data_in,
    input  logic [NUM_MASTERS-1:0]                 m_r_en,
    input  logic [NUM_MASTERS-1:0]                 m_w_en,
    output logic [NUM_MASTERS-1:0]                 m_cplt,
    output logic [DATA_WIDTH-1:0]                  m_data_out,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_data_in,
    output logic                                   mem_r_en,
    output logic                                   mem_w_en,
    input  logic                                   mem_rdy,
    input  logic                                   mem_cplt,
    input  logic [DATA_WIDTH-1:0]                  mem_data_out,
    output logic [GW-1:0]                          grant_id,
    output logic                                   arb_busy
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                                   timeout_err
`endif
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: illegal parameter value");
    end

    arb_state_e              state_q;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           rr_ptr_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_data_q;
    logic                    mem_r_en_q;
    logic                    mem_w_en_q;
    logic [NUM_MASTERS-1:0]  m_cplt_q;
    logic [DATA_WIDTH-1:0]   m_data_out_q;
    logic [GW-1:0]           pick_idx;
    logic                    pick_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_err_q;
`endif

    mem_arb_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req_i    (m_r_en | m_w_en),
        .ptr_i    (rr_ptr_q),
        .rr_mode_i(RR_EN != 0),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= GW'(NUM_MASTERS - 1);
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            m_cplt_q     <= '0;
            m_data_out_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Write wins when a master raises both enables
                    if (mem_rdy && pick_valid) begin
                        state_q    <= ST_ISSUE;
                        grant_q    <= pick_idx;
                        mem_addr_q <= m_addr[pick_idx];
                        mem_data_q <= m_data_in[pick_idx];
                        mem_w_en_q <= m_w_en[pick_idx];
                        mem_r_en_q <= !m_w_en[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    state_q    <= ST_WAIT;
                    mem_r_en_q <= 1'b0;
                    mem_w_en_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_q  <= '0;
`endif
                end
                ST_WAIT: begin
                    if (mem_cplt) begin
                        state_q            <= ST_DONE;
                        m_cplt_q[grant_q]  <= 1'b1;
                        m_data_out_q       <= mem_data_out;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q           <= ST_DONE;
                        m_cplt_q[grant_q] <= 1'b1;
                        m_data_out_q      <= '0;
                        timeout_err_q     <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    m_cplt_q     <= '0;
                    m_data_out_q <= '0;
                    rr_ptr_q     <= grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    timeout_err_q <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_cplt      = m_cplt_q;
    assign m_data_out  = m_data_out_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != ST_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: DUT 0 is round-robin, DUT 1 fixed priority, sharing one stimulus.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM-1:0][AW-1:0] m_addr;
    logic [NM-1:0][DW-1:0] m_data_in;
    logic [NM-1:0]         m_r_en, m_w_en;
    logic                  mem_rdy, mem_cplt;
    logic [DW-1:0]         mem_data_out;

    logic [NM-1:0] m_cplt_w      [2];
    logic [DW-1:0] m_data_out_w  [2];
    logic [AW-1:0] mem_addr_w    [2];
    logic [DW-1:0] mem_data_in_w [2];
    logic          mem_r_en_w    [2];
    logic          mem_w_en_w    [2];
    logic [0:0]    grant_w       [2];
    logic          arb_busy_w    [2];
    logic          timeout_err_w [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_arbiter #(
            .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .RR_EN(gi == 0 ? 1 : 0), .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .m_addr      (m_addr),
            .m_data_in   (m_data_in),
            .m_r_en      (m_r_en),
            .m_w_en      (m_w_en),
            .m_cplt      (m_cplt_w[gi]),
            .m_data_out  (m_data_out_w[gi]),
            .mem_addr    (mem_addr_w[gi]),
            .mem_data_in (mem_data_in_w[gi]),
            .mem_r_en    (mem_r_en_w[gi]),
            .mem_w_en    (mem_w_en_w[gi]),
            .mem_rdy     (mem_rdy),
            .mem_cplt    (mem_cplt),
            .mem_data_out(mem_data_out),
            .grant_id    (grant_w[gi]),
            .arb_busy    (arb_busy_w[gi])
`ifdef MEM_ARB_TIMEOUT_EN
            ,
            .timeout_err (timeout_err_w[gi])
`endif
        );
`ifndef MEM_ARB_TIMEOUT_EN
        assign timeout_err_w[gi] = 1'b0;
`endif
    end

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int          gnt;
    } iss_t;

    typedef struct {
        int          gnt;
        logic [DW-1:0] data;
        bit          tmo;
    } cpl_t;

    iss_t iss_q0[$], iss_q1[$];
    cpl_t cpl_q0[$], cpl_q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic void check(input string name, input int d, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h required 0x%0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endfunction

    function automatic bit pop_iss(input int d, output iss_t e);
        if (d == 0) begin
            if (iss_q0.size() == 0) return 1'b0;
            e = iss_q0.pop_front();
        end else begin
            if (iss_q1.size() == 0) return 1'b0;
            e = iss_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_cpl(input int d, output cpl_t c);
        if (d == 0) begin
            if (cpl_q0.size() == 0) return 1'b0;
            c = cpl_q0.pop_front();
        end else begin
            if (cpl_q1.size() == 0) return 1'b0;
            c = cpl_q1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic expect_txn(input int d, input int g, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input bit tmo, input bit with_cplt);
        iss_t i;
        cpl_t c;
        i.we = we; i.addr = addr; i.data = wdata; i.gnt = g;
        c.gnt = g; c.data = rdata; c.tmo = tmo;
        if (d == 0) begin
            iss_q0.push_back(i);
            if (with_cplt) cpl_q0.push_back(c);
        end else begin
            iss_q1.push_back(i);
            if (with_cplt) cpl_q1.push_back(c);
        end
    endtask

    // Monitor: pops expectations whenever a DUT issues or completes
    bit prev_en   [2];
    int issue_cyc [2];
    always @(posedge clk) begin
        iss_t e;
        cpl_t c;
        bit   ok;
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (mem_r_en_w[d] || mem_w_en_w[d]) begin
                ok = pop_iss(d, e);
                check("issue_expected", d, 32'(ok), 32'd1);
                if (ok) begin
                    $display("dut%0d issue: cyc=%0d gnt=%0d we=%0b addr=0x%06h data=0x%04h", d, cyc,
                             grant_w[d], mem_w_en_w[d], mem_addr_w[d], mem_data_in_w[d]);
                    check("mem_w_en", d, 32'(mem_w_en_w[d]), 32'(e.we));
                    check("mem_r_en", d, 32'(mem_r_en_w[d]), 32'(!e.we));
                    check("mem_addr", d, 32'(mem_addr_w[d]), 32'(e.addr));
                    check("grant_id", d, 32'(grant_w[d]), 32'(e.gnt));
                    if (e.we) check("mem_data_in", d, 32'(mem_data_in_w[d]), 32'(e.data));
                end
                check("en_single_cycle", d, 32'(prev_en[d]), 32'd0);
                issue_cyc[d] = cyc;
            end
            prev_en[d] = mem_r_en_w[d] || mem_w_en_w[d];
            if (m_cplt_w[d] != '0) begin
                ok = pop_cpl(d, c);
                check("cplt_expected", d, 32'(ok), 32'd1);
                if (ok) begin
                    $display("dut%0d cplt: cyc=%0d m_cplt=%b data=0x%04h tmo=%0b", d, cyc,
                             m_cplt_w[d], m_data_out_w[d], timeout_err_w[d]);
                    check("m_cplt", d, 32'(m_cplt_w[d]), 32'(1 << c.gnt));
                    check("m_data_out", d, 32'(m_data_out_w[d]), 32'(c.data));
                    check("timeout_err", d, 32'(timeout_err_w[d]), 32'(c.tmo));
                    if (c.tmo) check("timeout_latency", d, 32'(cyc - issue_cyc[d]), 32'(TMO + 1));
                    else       check("cplt_latency", d, 32'(mem_cplt), 32'd1);
                end
            end else if (timeout_err_w[d]) begin
                check("timeout_err_stray", d, 32'(timeout_err_w[d]), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input int d);
        check("rst_m_cplt", d, 32'(m_cplt_w[d]), 32'd0);
        check("rst_m_data_out", d, 32'(m_data_out_w[d]), 32'd0);
        check("rst_mem_addr", d, 32'(mem_addr_w[d]), 32'd0);
        check("rst_mem_data_in", d, 32'(mem_data_in_w[d]), 32'd0);
        check("rst_mem_r_en", d, 32'(mem_r_en_w[d]), 32'd0);
        check("rst_mem_w_en", d, 32'(mem_w_en_w[d]), 32'd0);
        check("rst_grant_id", d, 32'(grant_w[d]), 32'd0);
        check("rst_arb_busy", d, 32'(arb_busy_w[d]), 32'd0);
        check("rst_timeout_err", d, 32'(timeout_err_w[d]), 32'd0);
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mem_r_en_w[0] || mem_w_en_w[0]) && n < 50);
        check("issue_seen", 0, 32'(mem_r_en_w[0] || mem_w_en_w[0]), 32'd1);
    endtask

    // Controller model: optional ignored completion during ISSUE, then a real one in WAIT
    task automatic serve(input logic [DW-1:0] rdata, input int delay, input bit early_cplt,
                         input bit drop_req, output int n);
        wait_issue(n);
        if (early_cplt) begin
            @(negedge clk);
            mem_cplt = 1'b1;
            mem_data_out = 16'hDEAD;
            if (drop_req) begin m_r_en = '0; m_w_en = '0; end
            @(negedge clk);
            mem_cplt = 1'b0;
        end
        repeat (delay) @(posedge clk);
        @(negedge clk);
        mem_cplt = 1'b1;
        mem_data_out = rdata;
        @(negedge clk);
        mem_cplt = 1'b0;
    endtask

    task automatic wait_cplt(input int limit);
        int n = 0;
        while (m_cplt_w[0] == '0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cplt_seen", 0, 32'(m_cplt_w[0] != '0), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_addr = '0; m_data_in = '0; m_r_en = '0; m_w_en = '0;
        mem_rdy = 1'b1; mem_cplt = 1'b0; mem_data_out = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_all_zero(d);
        rst_n = 1'b1;

        // Master 1 reads 0x000010, controller returns 0xBEEF
        @(negedge clk);
        m_addr[1] = 24'h000010;
        m_r_en[1] = 1'b1;
        for (int d = 0; d < 2; d++) expect_txn(d, 1, 1'b0, 24'h000010, 16'h0, 16'hBEEF, 1'b0, 1'b1);
        serve(16'hBEEF, 2, 1'b0, 1'b0, n);
        check("issue_latency", 0, 32'(n), 32'd1);
        wait_cplt(20);
        m_r_en = '0;

        // Completion while idle must be ignored
        @(negedge clk);
        mem_cplt = 1'b1;
        mem_data_out = 16'h5A5A;
        @(negedge clk);
        mem_cplt = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check("idle_busy", d, 32'(arb_busy_w[d]), 32'd0);

        // Both masters request continuously for four transactions
        m_addr[0] = 24'h000100;
        m_addr[1] = 24'h000200;
        m_r_en = 2'b11;
        for (int t = 0; t < 4; t++) begin
            expect_txn(0, t % 2, 1'b0, (t % 2 == 1) ? 24'h000200 : 24'h000100, 16'h0,
                       16'hA000 + 16'(t), 1'b0, 1'b1);
            expect_txn(1, 0, 1'b0, 24'h000100, 16'h0, 16'hA000 + 16'(t), 1'b0, 1'b1);
        end
        for (int t = 0; t < 4; t++) begin
            serve(16'hA000 + 16'(t), 1, 1'b0, 1'b0, n);
            wait_cplt(20);
        end
        m_r_en = '0;

        // Completion during ISSUE ignored; request dropped mid-transaction still completes
        @(negedge clk);
        m_addr[1] = 24'h000777;
        m_r_en[1] = 1'b1;
        for (int d = 0; d < 2; d++) expect_txn(d, 1, 1'b0, 24'h000777, 16'h0, 16'hC3C3, 1'b0, 1'b1);
        serve(16'hC3C3, 0, 1'b1, 1'b1, n);
        wait_cplt(20);

        // Read and write both raised: treated as a write
        @(negedge clk);
        m_addr[0] = 24'h000055;
        m_data_in[0] = 16'h1234;
        m_r_en[0] = 1'b1;
        m_w_en[0] = 1'b1;
        for (int d = 0; d < 2; d++) expect_txn(d, 0, 1'b1, 24'h000055, 16'h1234, 16'h0F0F, 1'b0, 1'b1);
        serve(16'h0F0F, 3, 1'b0, 1'b0, n);
        wait_cplt(20);
        m_r_en = '0;
        m_w_en = '0;

        // Reset during WAIT abandons the transaction
        @(negedge clk);
        m_addr[0] = 24'h000333;
        m_r_en[0] = 1'b1;
        for (int d = 0; d < 2; d++) expect_txn(d, 0, 1'b0, 24'h000333, 16'h0, 16'h0, 1'b0, 1'b0);
        wait_issue(n);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_all_zero(d);
        m_r_en = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_cplt = 1'b1;
        mem_data_out = 16'h9999;
        @(negedge clk);
        mem_cplt = 1'b0;
        repeat (5) @(negedge clk);

        // After reset the round-robin search starts at master 0
        m_addr[0] = 24'h000400;
        m_addr[1] = 24'h000500;
        m_r_en = 2'b11;
        for (int d = 0; d < 2; d++) expect_txn(d, 0, 1'b0, 24'h000400, 16'h0, 16'h7777, 1'b0, 1'b1);
        serve(16'h7777, 1, 1'b0, 1'b0, n);
        wait_cplt(20);
        m_r_en = '0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Controller never completes: watchdog ends the transaction with zero data
        @(negedge clk);
        mem_data_out = 16'hFFFF;
        m_addr[1] = 24'h000999;
        m_r_en[1] = 1'b1;
        for (int d = 0; d < 2; d++) expect_txn(d, 1, 1'b0, 24'h000999, 16'h0, 16'h0, 1'b1, 1'b1);
        wait_issue(n);
        wait_cplt(40);
        m_r_en = '0;
`endif

        repeat (4) @(negedge clk);
        check("iss_q0_drained", 0, 32'(iss_q0.size()), 32'd0);
        check("iss_q1_drained", 1, 32'(iss_q1.size()), 32'd0);
        check("cpl_q0_drained", 0, 32'(cpl_q0.size()), 32'd0);
        check("cpl_q1_drained", 1, 32'(cpl_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
